// File: rtl/dm_arbiter_if.sv
// Requester-side bundle for one data-memory arbiter port.
// The requester (CPU load/store path or debug/DMA path) uses the master
// modport; the arbiter uses the slave modport.
interface dm_arbiter_if;

   // Request half: held stable by the requester until gnt is seen
   logic        req;
   logic        we;
   logic [9:0]  addr;
   logic [31:0] wdata;

   // Response half: gnt is combinational, rvalid is registered
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter and sequencer in front of the 1024x32 data memory.
// Port 0 is the CPU load/store path, port 1 the debug/DMA path.
// One memory operation is issued per cycle. Read data returns one cycle
// after the grant, together with a valid strobe for the owning port.
// ARB_MODE 0 is round-robin. ARB_MODE 1 gives fixed priority to port 0,
// with a starvation guard that forces port 1 through after STARVE_LIMIT
// consecutive denied cycles.
module dm_arbiter #(
   parameter int ARB_MODE     = 0,
   parameter int STARVE_LIMIT = 8
) (
   input  logic         clk,
   input  logic         rst,
   dm_arbiter_if.slave  p0,
   dm_arbiter_if.slave  p1,
   output logic [9:0]   dm_addr,
   output logic [31:0]  dm_din,
   output logic         dm_we,
   output logic         dm_rd,
   input  logic [31:0]  dm_dout
);

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   // Arbitration state
   port_t       last_gnt_q, last_gnt_d;
   logic [7:0]  starve_cnt_q, starve_cnt_d;

   // Read-return tracking: one flop per port doubles as the owner record
   logic        p0_rvalid_q, p0_rvalid_d;
   logic        p1_rvalid_q, p1_rvalid_d;

   // Combinational winner of the current cycle
   logic        win0;
   logic        win1;

   // Pick the winner from the current requests and the arbitration state.
   // Nothing is granted while reset is held low.
   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      if (ARB_MODE == 0) begin
         if (p0.req && p1.req) begin
            if (last_gnt_q == PORT0) begin
               win1 = 1'b1;
            end else begin
               win0 = 1'b1;
            end
         end else if (p0.req) begin
            win0 = 1'b1;
         end else if (p1.req) begin
            win1 = 1'b1;
         end
      end else begin
         if (p1.req && (!p0.req || (starve_cnt_q == LIMIT))) begin
            win1 = 1'b1;
         end else if (p0.req) begin
            win0 = 1'b1;
         end
      end
      if (!rst) begin
         win0 = 1'b0;
         win1 = 1'b0;
      end
   end

   // Steer the winner onto the memory bus. With no request the port 0
   // inputs pass through; the memory ignores them since we/rd are low.
   always_comb begin
      dm_addr = p0.addr;
      dm_din  = p0.wdata;
      dm_we   = 1'b0;
      dm_rd   = 1'b0;
      if (win1) begin
         dm_addr = p1.addr;
         dm_din  = p1.wdata;
         dm_we   = p1.we;
         dm_rd   = ~p1.we;
      end else if (win0) begin
         dm_we   = p0.we;
         dm_rd   = ~p0.we;
      end
   end

   // Next-state logic for the last grant, the starvation counter and the
   // read-return strobes.
   always_comb begin
      last_gnt_d   = last_gnt_q;
      starve_cnt_d = 8'd0;
      p0_rvalid_d  = win0 & ~p0.we;
      p1_rvalid_d  = win1 & ~p1.we;

      if (win0) begin
         last_gnt_d = PORT0;
      end else if (win1) begin
         last_gnt_d = PORT1;
      end

      // Count cycles in which port 1 waits; hold at the limit so the
      // forced grant stays pending until it actually happens.
      if ((ARB_MODE != 0) && p1.req && !win1) begin
         if (starve_cnt_q == LIMIT) begin
            starve_cnt_d = starve_cnt_q;
         end else begin
            starve_cnt_d = starve_cnt_q + 8'd1;
         end
      end
   end

   // Register arbitration state and read strobes. Reset drops any read
   // that is still in flight so no stale rvalid appears afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt_q   <= PORT0;
         starve_cnt_q <= 8'd0;
         p0_rvalid_q  <= 1'b0;
         p1_rvalid_q  <= 1'b0;
      end else begin
         last_gnt_q   <= last_gnt_d;
         starve_cnt_q <= starve_cnt_d;
         p0_rvalid_q  <= p0_rvalid_d;
         p1_rvalid_q  <= p1_rvalid_d;
      end
   end

   // Port responses: grants are combinational, read data is shared
   always_comb begin
      p0.gnt    = win0;
      p1.gnt    = win1;
      p0.rvalid = p0_rvalid_q;
      p1.rvalid = p1_rvalid_q;
      p0.rdata  = dm_dout;
      p1.rdata  = dm_dout;
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a round-robin instance (A) and a fixed-priority
// instance with STARVE_LIMIT=3 (B), each with its own memory, checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_dm_arbiter;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
   } op_t;

   localparam int LIMIT_B = 3;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   dm_arbiter_if ifa0 ();
   dm_arbiter_if ifa1 ();
   dm_arbiter_if ifb0 ();
   dm_arbiter_if ifb1 ();

   op_t drv [2][2];

   logic [9:0]  dm_addr_a, dm_addr_b;
   logic [31:0] dm_din_a, dm_din_b;
   logic        dm_we_a, dm_we_b, dm_rd_a, dm_rd_b;
   logic [31:0] dout_a, dout_b;

   assign ifa0.req = drv[0][0].req;  assign ifa0.we = drv[0][0].we;
   assign ifa0.addr = drv[0][0].addr; assign ifa0.wdata = drv[0][0].wdata;
   assign ifa1.req = drv[0][1].req;  assign ifa1.we = drv[0][1].we;
   assign ifa1.addr = drv[0][1].addr; assign ifa1.wdata = drv[0][1].wdata;
   assign ifb0.req = drv[1][0].req;  assign ifb0.we = drv[1][0].we;
   assign ifb0.addr = drv[1][0].addr; assign ifb0.wdata = drv[1][0].wdata;
   assign ifb1.req = drv[1][1].req;  assign ifb1.we = drv[1][1].we;
   assign ifb1.addr = drv[1][1].addr; assign ifb1.wdata = drv[1][1].wdata;

   dm_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(8)) dut_a (
      .clk(clk), .rst(rst_n), .p0(ifa0), .p1(ifa1),
      .dm_addr(dm_addr_a), .dm_din(dm_din_a), .dm_we(dm_we_a),
      .dm_rd(dm_rd_a), .dm_dout(dout_a)
   );

   dm_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(LIMIT_B)) dut_b (
      .clk(clk), .rst(rst_n), .p0(ifb0), .p1(ifb1),
      .dm_addr(dm_addr_b), .dm_din(dm_din_b), .dm_we(dm_we_b),
      .dm_rd(dm_rd_b), .dm_dout(dout_b)
   );

   // Observed outputs gathered per instance
   logic [1:0]  obs_gnt [2];
   logic [1:0]  obs_rv [2];
   logic [31:0] obs_rdata [2][2];
   logic        obs_we [2];
   logic        obs_rd [2];
   logic [9:0]  obs_addr [2];
   logic [31:0] obs_din [2];

   assign obs_gnt[0] = {ifa1.gnt, ifa0.gnt};
   assign obs_gnt[1] = {ifb1.gnt, ifb0.gnt};
   assign obs_rv[0] = {ifa1.rvalid, ifa0.rvalid};
   assign obs_rv[1] = {ifb1.rvalid, ifb0.rvalid};
   assign obs_rdata[0][0] = ifa0.rdata;
   assign obs_rdata[0][1] = ifa1.rdata;
   assign obs_rdata[1][0] = ifb0.rdata;
   assign obs_rdata[1][1] = ifb1.rdata;
   assign obs_we[0] = dm_we_a;   assign obs_we[1] = dm_we_b;
   assign obs_rd[0] = dm_rd_a;   assign obs_rd[1] = dm_rd_b;
   assign obs_addr[0] = dm_addr_a; assign obs_addr[1] = dm_addr_b;
   assign obs_din[0] = dm_din_a;  assign obs_din[1] = dm_din_b;

   // Data memories: synchronous write, registered read
   bit [31:0] mem_a [1024];
   bit [31:0] mem_b [1024];

   always @(posedge clk) begin
      if (dm_we_a) mem_a[dm_addr_a] <= dm_din_a;
      if (dm_rd_a) dout_a <= mem_a[dm_addr_a];
   end

   always @(posedge clk) begin
      if (dm_we_b) mem_b[dm_addr_b] <= dm_din_b;
      if (dm_rd_b) dout_b <= mem_b[dm_addr_b];
   end

   // Reference model state
   bit [31:0]   ref_mem [2][1024];
   int          last_w [2];
   int          starve [2];
   bit          pend_v [2];
   int          pend_own [2];
   logic [31:0] pend_data [2];
   int          win [2];
   logic [1:0]  log_a [$];
   logic [1:0]  log_b [$];

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int d, input int p, input logic req, input logic we,
                         input logic [9:0] addr, input logic [31:0] wdata);
      drv[d][p] = '{req: req, we: we, addr: addr, wdata: wdata};
   endtask

   task automatic model_reset(input int d);
      last_w[d] = 0;
      starve[d] = 0;
      pend_v[d] = 1'b0;
   endtask

   // One clock cycle: check both instances mid-cycle, advance the model,
   // optionally assert reset late in the cycle after a grant was seen.
   task automatic applyStimulus(input bit late_reset);
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         int w;
         logic [1:0] eg;
         logic [1:0] erv;
         w = -1;
         if (rst_n) begin
            if (d == 0) begin
               if (drv[d][0].req && drv[d][1].req) w = 1 - last_w[d];
               else if (drv[d][0].req) w = 0;
               else if (drv[d][1].req) w = 1;
            end else begin
               if (drv[d][1].req && (!drv[d][0].req || starve[d] == LIMIT_B)) w = 1;
               else if (drv[d][0].req) w = 0;
            end
         end
         eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
         if (d == 0) log_a.push_back(obs_gnt[0]);
         else log_b.push_back(obs_gnt[1]);
         checkOutput($sformatf("gnt[%0d]", d), 32'(obs_gnt[d]), 32'(eg));
         checkOutput($sformatf("dm_we[%0d]", d), 32'(obs_we[d]), 32'((w >= 0) && drv[d][w < 0 ? 0 : w].we));
         checkOutput($sformatf("dm_rd[%0d]", d), 32'(obs_rd[d]), 32'((w >= 0) && !drv[d][w < 0 ? 0 : w].we));
         if (w >= 0) begin
            checkOutput($sformatf("dm_addr[%0d]", d), 32'(obs_addr[d]), 32'(drv[d][w].addr));
            if (drv[d][w].we)
               checkOutput($sformatf("dm_din[%0d]", d), obs_din[d], drv[d][w].wdata);
         end
         erv = (rst_n && pend_v[d]) ? ((pend_own[d] == 0) ? 2'b01 : 2'b10) : 2'b00;
         checkOutput($sformatf("rvalid[%0d]", d), 32'(obs_rv[d]), 32'(erv));
         if (erv != 2'b00)
            checkOutput($sformatf("rdata[%0d]", d), obs_rdata[d][pend_own[d]], pend_data[d]);

         win[d] = w;
         if (!rst_n || late_reset) begin
            model_reset(d);
         end else begin
            if (w >= 0) begin
               last_w[d] = w;
               if (drv[d][w].we) begin
                  ref_mem[d][drv[d][w].addr] = drv[d][w].wdata;
                  pend_v[d] = 1'b0;
               end else begin
                  pend_v[d] = 1'b1;
                  pend_own[d] = w;
                  pend_data[d] = ref_mem[d][drv[d][w].addr];
               end
            end else begin
               pend_v[d] = 1'b0;
            end
            if (d == 1) begin
               if (drv[d][1].req && w != 1) starve[d] = (starve[d] < LIMIT_B) ? starve[d] + 1 : LIMIT_B;
               else starve[d] = 0;
            end
         end
      end
      if (late_reset) begin
         #2;
         rst_n = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] rr_pat [6];
      logic [1:0] fp_pat [8];
      int idx_a;
      int idx_b;
      rr_pat = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      fp_pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

      model_reset(0);
      model_reset(1);

      // Reset held with both ports requesting on both instances
      rst_n = 1'b0;
      set_op(0, 0, 1'b1, 1'b0, 10'h010, 32'h0);
      set_op(0, 1, 1'b1, 1'b0, 10'h020, 32'h0);
      set_op(1, 0, 1'b1, 1'b0, 10'h001, 32'h0);
      set_op(1, 1, 1'b1, 1'b0, 10'h002, 32'h0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);

      // Release: round-robin goes to port 1 first; B starts its pattern
      rst_n = 1'b1;
      idx_b = log_b.size();
      applyStimulus(1'b0);
      checkOutput("rr_first_gnt", 32'(log_a[log_a.size() - 1]), 32'h2);
      set_op(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
      applyStimulus(1'b0);

      // Port 1 write, then port 0 write/read of the same address
      set_op(0, 0, 1'b0, 1'b0, 10'h0, 32'h0);
      set_op(0, 1, 1'b1, 1'b1, 10'h006, 32'hCAFEF00D);
      applyStimulus(1'b0);
      set_op(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
      set_op(0, 0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
      applyStimulus(1'b0);
      set_op(0, 0, 1'b1, 1'b0, 10'h005, 32'h0);
      applyStimulus(1'b0);
      checkOutput("raw_rvalid", 32'(obs_rv[0]), 32'h1);
      checkOutput("raw_rdata", obs_rdata[0][0], 32'hDEADBEEF);

      // Round-robin contention for six cycles
      set_op(0, 1, 1'b1, 1'b0, 10'h006, 32'h0);
      idx_a = log_a.size();
      for (int k = 0; k < 6; k++) applyStimulus(1'b0);
      for (int k = 0; k < 6; k++)
         checkOutput($sformatf("rr_pattern_%0d", k), 32'(log_a[idx_a + k]), 32'(rr_pat[k]));
      for (int k = 0; k < 8; k++)
         checkOutput($sformatf("starve_pattern_%0d", k), 32'(log_b[idx_b + k]), 32'(fp_pat[k]));
      set_op(0, 0, 1'b0, 1'b0, 10'h0, 32'h0);
      set_op(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
      applyStimulus(1'b0);

      // Reset asserted while a port 1 read is in flight
      set_op(0, 1, 1'b1, 1'b0, 10'h006, 32'h0);
      applyStimulus(1'b1);
      checkOutput("mid_rst_rvalid", 32'(obs_rv[0]), 32'h0);
      set_op(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
      applyStimulus(1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b0);
      checkOutput("post_rst_rvalid", 32'(obs_rv[0]), 32'h0);
      applyStimulus(1'b0);

      // Mixed pipeline: p0 write then p1 read of 0x3FF
      set_op(0, 1, 1'b1, 1'b0, 10'h001, 32'h0);
      applyStimulus(1'b0);
      set_op(0, 0, 1'b1, 1'b1, 10'h3FF, 32'h12345678);
      set_op(0, 1, 1'b1, 1'b0, 10'h3FF, 32'h0);
      applyStimulus(1'b0);
      set_op(0, 0, 1'b0, 1'b0, 10'h0, 32'h0);
      applyStimulus(1'b0);
      set_op(0, 1, 1'b0, 1'b0, 10'h0, 32'h0);
      checkOutput("mixed_rvalid", 32'(obs_rv[0]), 32'h2);
      checkOutput("mixed_rdata", obs_rdata[0][1], 32'h12345678);
      applyStimulus(1'b0);

      // Randomized traffic obeying the hold-until-grant handshake
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
               if (!(drv[d][p].req && win[d] != p && rst_n)) begin
                  set_op(d, p, ($urandom % 4) != 0, $urandom % 2,
                         10'($urandom % 16), $urandom);
               end
            end
         end
         rst_n = ($urandom % 60) != 0;
         applyStimulus(1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 1024x32 data memory (registered read, 1-cycle read latency, synchronous write).
- Port 0 is the CPU load/store path; port 1 is the debug/DMA path.
- Issues at most one memory operation per cycle, returns read data with a valid strobe, and prevents starvation of either port.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to port 0 with starvation guard.
- STARVE_LIMIT, 8, ARB_MODE=1 only: consecutive denied cycles after which port 1 is forced through (range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; level, held until p0_gnt.
- p0_we  in  1  port 0 op: 1 = write, 0 = read.
- p0_addr  in  10  port 0 word address [11:2].
- p0_wdata  in  32  port 0 write data.
- p0_gnt  out  1  port 0 op issued this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  32  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- dm_addr  out  10  memory word address [11:2].
- dm_din  out  32  memory write data.
- dm_we  out  1  memory write enable.
- dm_rd  out  1  memory read enable.
- dm_dout  in  32  memory registered read data.

Behaviour:
- Reset (rst=0), asynchronous:
  - last_gnt=0, starve_cnt=0, p0_rvalid=p1_rvalid=0, rd_owner cleared.
  - While rst=0: p0_gnt, p1_gnt, dm_we, dm_rd forced to 0.
  - Reset during an in-flight read discards it; no rvalid follows deassertion.
- Grant is combinational from req and arbitration state, with exactly one issue per cycle. The winner's addr/wdata drive dm_addr/dm_din in the same cycle. dm_we=winner_we and dm_rd=~winner_we.
- No request: dm_we=dm_rd=0, dm_addr/dm_din=port 0 inputs (don't-care).
- Handshake:
  - A requester sees gnt=1 in the cycle its op is sampled by the memory at the next edge.
  - It may drop req or present a new op from the following cycle.
  - req held with gnt=0 must keep addr/we/wdata stable.
- Round-robin (ARB_MODE=0):
  - Single requester wins.
  - Both requesting: the port != last_gnt wins.
  - last_gnt <= winner on every grant.
- Fixed priority (ARB_MODE=1):
  - Port 0 wins when requesting, unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
  - starve_cnt: +1 each cycle p1_req=1 and p1_gnt=0 (saturates at STARVE_LIMIT); cleared on p1_gnt or p1_req=0.
- Read return:
  - A read granted in cycle N gives pX_rvalid=1 in cycle N+1 only, for the owning port; rd_owner is registered at grant.
  - pX_rdata = dm_dout, continuously; meaningful only when rvalid=1.
  - Back-to-back reads (either port) are fully pipelined, one per cycle.
- Writes: no response strobe; complete at the edge ending the grant cycle.
- Read-after-write same address, consecutive cycles: the read returns the new data (memory writes at edge N+1; the read is sampled at edge N+2).
- Simultaneous rvalid for one port and gnt for the other is legal.

Test Plan:
- Reset: hold rst=0 with both req=1 -> gnt, dm_we, dm_rd, rvalid all 0. Release -> first grant in round-robin goes to port 1 (last_gnt=0).
- Single-port write/read: p0 writes 0xDEADBEEF to addr 0x005, then reads addr 0x005 next cycle -> p0_gnt both cycles, p0_rvalid=1 one cycle later with p0_rdata=0xDEADBEEF, p1_rvalid=0.
- Round-robin contention: both ports request reads continuously for 6 cycles -> grants alternate 1,0,1,0,1,0 and rvalid alternates one cycle behind with the correct owner's data.
- Fixed priority starvation, ARB_MODE=1, STARVE_LIMIT=3: p0_req and p1_req held high -> p0 granted 3 cycles, p1 granted on the 4th, counter cleared, then the pattern repeats.
- Reset mid-read: p1 read granted, rst=0 asserted before the next edge -> p1_rvalid stays 0 through and after reset release.
- Mixed pipeline: p0 write addr 0x3FF=0x12345678 while p1 requests read addr 0x3FF -> p0 granted first (round-robin from last_gnt=1), p1 granted next cycle, p1_rdata=0x12345678.
